// File: rtl/wb_merge_pkg.sv
// Shared constants and the write-port record for the write-back merger.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_merge_pkg;

   localparam int   ADDR_W_DEF   = 5;
   localparam int   DATA_W_DEF   = 32;
   localparam logic WRITE_ENABLE = 1'b1;
   localparam int   REG_NOP      = 0;     // register 0 is hard-wired, writes to it are dropped
   localparam logic RST_ENABLE   = 1'b1;  // resetn is active-high in this block

   // Register-file write port at default widths.
   typedef struct packed {
      logic                  we;
      logic [ADDR_W_DEF-1:0] wa;
      logic [DATA_W_DEF-1:0] wd;
   } wb_port_t;

endpackage

// File: rtl/wb_lt_fifo.sv
// Circular buffer for long-latency results: 0/1 push, 0/1/2 pop, head and head+1 peek.
// Latency: push visible at head the cycle after the write; cnt and pend_mask are registered state.
// Backpressure: none internally; the caller must not push when cnt == DEPTH.
// Ports: clk, resetn (async, active-high), push/push_wa/push_wd, pop (entries removed),
//        head_*/nxt_* (peek), cnt (occupancy), pend_mask (OR of held destinations).
module wb_lt_fifo
   import wb_merge_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int ADDR_W = ADDR_W_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   localparam int CNT_W  = $clog2(DEPTH) + 1,
   localparam int PTR_W  = $clog2(DEPTH)
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   push,
   input  logic [ADDR_W-1:0]      push_wa,
   input  logic [DATA_W-1:0]      push_wd,
   input  logic [1:0]             pop,
   output logic [ADDR_W-1:0]      head_wa,
   output logic [DATA_W-1:0]      head_wd,
   output logic [ADDR_W-1:0]      nxt_wa,
   output logic [DATA_W-1:0]      nxt_wd,
   output logic [CNT_W-1:0]       cnt,
   output logic [(1<<ADDR_W)-1:0] pend_mask
);

   logic [ADDR_W-1:0] mem_wa [DEPTH];
   logic [DATA_W-1:0] mem_wd [DEPTH];
   logic [PTR_W-1:0]  rd_ptr;
   logic [PTR_W-1:0]  wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge resetn) begin
      if (resetn == RST_ENABLE) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_W'(1);
         rd_ptr <= rd_ptr + PTR_W'(pop);
         cnt    <= cnt + CNT_W'(push) - CNT_W'(pop);
      end
   end

   // Storage is not reset: occupancy alone decides which slots are meaningful.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_wa[wr_ptr] <= push_wa;
         mem_wd[wr_ptr] <= push_wd;
      end
   end

   assign head_wa = mem_wa[rd_ptr];
   assign head_wd = mem_wd[rd_ptr];
   assign nxt_wa  = mem_wa[rd_ptr + PTR_W'(1)];
   assign nxt_wd  = mem_wd[rd_ptr + PTR_W'(1)];

   always_comb begin
      pend_mask = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (CNT_W'(k) < cnt)
            pend_mask[mem_wa[rd_ptr + PTR_W'(k)]] = 1'b1;
      end
   end

endmodule

// File: rtl/wb_merge.sv
// Merges two in-order result pipes and a buffered long-latency source onto two regfile write ports.
// Latency: one cycle, inputs at cycle N drive wb1_*/wb2_* at N+1; long-latency writes may wait in the FIFO.
// Backpressure: in-order pipes are never stalled; lt_ready drops only when the FIFO is full.
// Ports: clk, resetn (async, active-high), i1_*/i2_* (older/younger in-order writes),
//        lt_valid/lt_ready/lt_wa/lt_wd (long-latency source), wb1_*/wb2_* (registered write ports),
//        pend_mask, fifo_cnt, wb_conflict (sticky collision flag).
module wb_merge
   import wb_merge_pkg::*;
#(
   parameter  int DEPTH  = 4,
   parameter  int ADDR_W = ADDR_W_DEF,
   parameter  int DATA_W = DATA_W_DEF,
   localparam int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   resetn,
   input  logic                   i1_we,
   input  logic [ADDR_W-1:0]      i1_wa,
   input  logic [DATA_W-1:0]      i1_wd,
   input  logic                   i2_we,
   input  logic [ADDR_W-1:0]      i2_wa,
   input  logic [DATA_W-1:0]      i2_wd,
   input  logic                   lt_valid,
   output logic                   lt_ready,
   input  logic [ADDR_W-1:0]      lt_wa,
   input  logic [DATA_W-1:0]      lt_wd,
   output logic                   wb1_we,
   output logic [ADDR_W-1:0]      wb1_wa,
   output logic [DATA_W-1:0]      wb1_wd,
   output logic                   wb2_we,
   output logic [ADDR_W-1:0]      wb2_wa,
   output logic [DATA_W-1:0]      wb2_wd,
   output logic [(1<<ADDR_W)-1:0] pend_mask,
   output logic [CNT_W-1:0]       fifo_cnt,
   output logic                   wb_conflict
);

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] wa;
      logic [DATA_W-1:0] wd;
   } wr_t;

   localparam wr_t NOP_WR = '0;

   logic              e1, e2;
   logic              lt_take, push, byp, hit, go;
   logic [1:0]        nfree, ndr, deq;
   logic [ADDR_W-1:0] head_wa, nxt_wa;
   logic [DATA_W-1:0] head_wd, nxt_wd;
   wr_t               cand [3];
   wr_t               dr   [2];
   wr_t               p1, p2;

   wb_lt_fifo #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_fifo (
      .clk       (clk),
      .resetn    (resetn),
      .push      (push),
      .push_wa   (lt_wa),
      .push_wd   (lt_wd),
      .pop       (deq),
      .head_wa   (head_wa),
      .head_wd   (head_wd),
      .nxt_wa    (nxt_wa),
      .nxt_wd    (nxt_wd),
      .cnt       (fifo_cnt),
      .pend_mask (pend_mask)
   );

   always_comb begin
      e1 = (i1_we == WRITE_ENABLE) & (i1_wa != ADDR_W'(REG_NOP));
      e2 = (i2_we == WRITE_ENABLE) & (i2_wa != ADDR_W'(REG_NOP));
      // Same-cycle WAW between the pair: the younger result is the architectural one.
      if (e1 & e2 & (i1_wa == i2_wa))
         e1 = 1'b0;

      lt_ready = (fifo_cnt < CNT_W'(DEPTH)) & (resetn != RST_ENABLE);
      // Writes to register 0 are accepted and silently dropped.
      lt_take  = lt_valid & lt_ready & (lt_wa != ADDR_W'(REG_NOP));

      // Candidates oldest-first; .we marks the candidate as present.
      cand[0].we = (fifo_cnt != '0);
      cand[0].wa = head_wa;
      cand[0].wd = head_wd;
      cand[1].we = (fifo_cnt >= CNT_W'(2));
      cand[1].wa = nxt_wa;
      cand[1].wd = nxt_wd;
      cand[2].we = lt_take;
      cand[2].wa = lt_wa;
      cand[2].wd = lt_wd;

      nfree = {1'b0, ~e1} + {1'b0, ~e2};
      go    = 1'b1;
      byp   = 1'b0;
      hit   = 1'b0;
      ndr   = 2'd0;
      deq   = 2'd0;
      dr[0] = NOP_WR;
      dr[1] = NOP_WR;

      // Walk candidates in age order and stop at the first one that cannot go,
      // so a long-latency write never overtakes an older one.
      for (int k = 0; k < 3; k++) begin
         if (go && cand[k].we) begin
            if (k == 1 && cand[1].wa == cand[0].wa)
               go = 1'b0;                       // keep same-register FIFO writes in separate cycles
            else if (k == 2 && CNT_W'(deq) != fifo_cnt)
               go = 1'b0;                       // bypass only behind a fully drained FIFO
            else if ((e1 && cand[k].wa == i1_wa) || (e2 && cand[k].wa == i2_wa)) begin
               hit = 1'b1;                      // in-order write wins this cycle
               go  = 1'b0;
            end else if (ndr == nfree)
               go = 1'b0;
            else begin
               dr[ndr[0]] = cand[k];
               ndr        = ndr + 2'd1;
               if (k == 2)
                  byp = 1'b1;
               else
                  deq = deq + 2'd1;
            end
         end
      end

      push = lt_take & ~byp;

      // Port 1 is filled before port 2; drained entries already carry we=1.
      p1 = e1 ? '{we: WRITE_ENABLE, wa: i1_wa, wd: i1_wd} : dr[0];
      if (e2)
         p2 = '{we: WRITE_ENABLE, wa: i2_wa, wd: i2_wd};
      else if (e1)
         p2 = dr[0];
      else
         p2 = dr[1];
   end

   always_ff @(posedge clk or posedge resetn) begin
      if (resetn == RST_ENABLE) begin
         wb1_we      <= 1'b0;
         wb1_wa      <= '0;
         wb1_wd      <= '0;
         wb2_we      <= 1'b0;
         wb2_wa      <= '0;
         wb2_wd      <= '0;
         wb_conflict <= 1'b0;
      end else begin
         wb1_we <= p1.we;
         wb1_wa <= p1.wa;
         wb1_wd <= p1.wd;
         wb2_we <= p2.we;
         wb2_wa <= p2.wa;
         wb2_wd <= p2.wd;
         if (hit)
            wb_conflict <= 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_merge.sv
// Self-checking bench for wb_merge: directed scenarios plus random traffic against a queue model.
// Latency: outputs checked one cycle after the inputs that produce them.
// Backpressure: source drops a beat when lt_ready is low.
module tb_wb_merge;

   localparam int DEPTH = 4;
   localparam int AW    = 5;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          resetn = 1'b1;
   logic          i1_we = 1'b0, i2_we = 1'b0, lt_valid = 1'b0;
   logic [AW-1:0] i1_wa = '0, i2_wa = '0, lt_wa = '0;
   logic [DW-1:0] i1_wd = '0, i2_wd = '0, lt_wd = '0;
   logic          lt_ready, wb1_we, wb2_we, wb_conflict;
   logic [AW-1:0] wb1_wa, wb2_wa;
   logic [DW-1:0] wb1_wd, wb2_wd;
   logic [31:0]   pend_mask;
   logic [2:0]    fifo_cnt;

   wb_merge #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .resetn(resetn),
      .i1_we(i1_we), .i1_wa(i1_wa), .i1_wd(i1_wd),
      .i2_we(i2_we), .i2_wa(i2_wa), .i2_wd(i2_wd),
      .lt_valid(lt_valid), .lt_ready(lt_ready), .lt_wa(lt_wa), .lt_wd(lt_wd),
      .wb1_we(wb1_we), .wb1_wa(wb1_wa), .wb1_wd(wb1_wd),
      .wb2_we(wb2_we), .wb2_wa(wb2_wa), .wb2_wd(wb2_wd),
      .pend_mask(pend_mask), .fifo_cnt(fifo_cnt), .wb_conflict(wb_conflict)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] wa;
      logic [DW-1:0] wd;
   } ent_t;

   ent_t          q[$];
   bit            exp_conf = 1'b0;
   logic          exp1_we, exp2_we;
   logic [AW-1:0] exp1_wa, exp2_wa;
   logic [DW-1:0] exp1_wd, exp2_wd;
   int            n_cmp = 0;
   int            n_bad = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
      end
   endtask

   function automatic logic [31:0] mask_of_q();
      logic [31:0] m = '0;
      foreach (q[i]) m[q[i].wa] = 1'b1;
      return m;
   endfunction

   // Reference: list candidates oldest-first, hand them to free ports until one must wait.
   task automatic model_step();
      bit   m1, m2, acc, byp;
      int   deq;
      int   ports[$];
      int   src[$];
      ent_t cl[$];
      ent_t dr[$];
      ent_t inc;
      m1  = i1_we && (i1_wa != 0);
      m2  = i2_we && (i2_wa != 0);
      if (m1 && m2 && i1_wa == i2_wa) m1 = 1'b0;
      acc = lt_valid && (q.size() < DEPTH) && (lt_wa != 0);
      byp = 1'b0;
      deq = 0;
      if (!m1) ports.push_back(1);
      if (!m2) ports.push_back(2);
      for (int k = 0; k < q.size() && k < 2; k++) begin
         cl.push_back(q[k]);
         src.push_back(k);
      end
      inc.wa = lt_wa;
      inc.wd = lt_wd;
      if (acc) begin
         cl.push_back(inc);
         src.push_back(2);
      end
      for (int j = 0; j < cl.size(); j++) begin
         if (src[j] == 1 && cl[j].wa == q[0].wa) break;
         if (src[j] == 2 && deq != q.size()) break;
         if ((m1 && cl[j].wa == i1_wa) || (m2 && cl[j].wa == i2_wa)) begin
            exp_conf = 1'b1;
            break;
         end
         if (dr.size() == ports.size()) break;
         dr.push_back(cl[j]);
         if (src[j] == 2) byp = 1'b1;
         else deq++;
      end
      exp1_we = m1; exp1_wa = m1 ? i1_wa : '0; exp1_wd = m1 ? i1_wd : '0;
      exp2_we = m2; exp2_wa = m2 ? i2_wa : '0; exp2_wd = m2 ? i2_wd : '0;
      for (int j = 0; j < dr.size(); j++) begin
         if (ports[j] == 1) begin
            exp1_we = 1'b1; exp1_wa = dr[j].wa; exp1_wd = dr[j].wd;
         end else begin
            exp2_we = 1'b1; exp2_wa = dr[j].wa; exp2_wd = dr[j].wd;
         end
      end
      for (int j = 0; j < deq; j++) q.delete(0);
      if (acc && !byp) q.push_back(inc);
   endtask

   // Called at posedge+1; returns at the next posedge+1 with outputs checked.
   task automatic step(input logic a_we, input logic [AW-1:0] a_wa, input logic [DW-1:0] a_wd,
                       input logic b_we, input logic [AW-1:0] b_wa, input logic [DW-1:0] b_wd,
                       input logic l_v,  input logic [AW-1:0] l_wa, input logic [DW-1:0] l_wd);
      i1_we = a_we; i1_wa = a_wa; i1_wd = a_wd;
      i2_we = b_we; i2_wa = b_wa; i2_wd = b_wd;
      lt_valid = l_v; lt_wa = l_wa; lt_wd = l_wd;
      #1;
      chk("lt_ready", 64'(lt_ready), 64'(q.size() < DEPTH));
      chk("fifo_cnt", 64'(fifo_cnt), 64'(q.size()));
      chk("pend_mask", 64'(pend_mask), 64'(mask_of_q()));
      model_step();
      @(posedge clk);
      #1;
      chk("wb1_we", 64'(wb1_we), 64'(exp1_we));
      chk("wb1_wa", 64'(wb1_wa), 64'(exp1_wa));
      chk("wb1_wd", 64'(wb1_wd), 64'(exp1_wd));
      chk("wb2_we", 64'(wb2_we), 64'(exp2_we));
      chk("wb2_wa", 64'(wb2_wa), 64'(exp2_wa));
      chk("wb2_wd", 64'(wb2_wd), 64'(exp2_wd));
      chk("wb_conflict", 64'(wb_conflict), 64'(exp_conf));
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic busy_lt(input logic [AW-1:0] wa, input logic [DW-1:0] wd);
      step(1, 3, 32'h33, 1, 4, 32'h44, 1, wa, wd);
   endtask

   // Asserts reset asynchronously mid-cycle, releases on a falling edge.
   task automatic do_reset();
      i1_we = 0; i2_we = 0; lt_valid = 0;
      resetn = 1'b1;
      #1;
      chk("rst_ready", 64'(lt_ready), 64'd0);
      chk("rst_cnt", 64'(fifo_cnt), 64'd0);
      chk("rst_mask", 64'(pend_mask), 64'd0);
      chk("rst_wb1_we", 64'(wb1_we), 64'd0);
      chk("rst_wb2_we", 64'(wb2_we), 64'd0);
      chk("rst_conf", 64'(wb_conflict), 64'd0);
      q.delete();
      exp_conf = 1'b0;
      @(negedge clk);
      resetn = 1'b0;
      @(posedge clk);
      #1;
      chk("rel_ready", 64'(lt_ready), 64'd1);
      chk("rel_cnt", 64'(fifo_cnt), 64'd0);
      chk("rel_mask", 64'(pend_mask), 64'd0);
      chk("rel_wb1_we", 64'(wb1_we), 64'd0);
      chk("rel_wb2_we", 64'(wb2_we), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      do_reset();

      // Same-cycle WAW: younger pipe wins.
      step(1, 5, 32'h11, 1, 5, 32'h22, 0, 0, 0);
      chk("waw_wb1_we", 64'(wb1_we), 64'd0);
      chk("waw_wb2_wa", 64'(wb2_wa), 64'd5);
      chk("waw_wb2_wd", 64'(wb2_wd), 64'h22);

      // Fill to full behind busy pipes; fifth beat is refused.
      for (int k = 0; k < 4; k++) busy_lt(7, 32'h70 + k);
      chk("full_ready", 64'(lt_ready), 64'd0);
      chk("full_cnt", 64'(fifo_cnt), 64'd4);
      chk("full_mask7", 64'(pend_mask[7]), 64'd1);
      busy_lt(7, 32'h74);
      idle();
      chk("same_wa_first", 64'(wb1_wd), 64'h70);
      chk("same_wa_p2_idle", 64'(wb2_we), 64'd0);
      repeat (4) idle();

      // Distinct addresses drain two per cycle in order.
      for (int k = 0; k < 4; k++) busy_lt(AW'(10 + k), 32'hA0 + k);
      idle();
      chk("two_p1_wa", 64'(wb1_wa), 64'd10);
      chk("two_p2_wa", 64'(wb2_wa), 64'd11);
      idle();
      chk("two_p1_wa_b", 64'(wb1_wa), 64'd12);
      chk("two_p2_wa_b", 64'(wb2_wa), 64'd13);

      // Bypass with empty FIFO.
      step(0, 0, 0, 0, 0, 0, 1, 9, 32'hAB);
      chk("byp_we", 64'(wb1_we), 64'd1);
      chk("byp_wa", 64'(wb1_wa), 64'd9);
      chk("byp_wd", 64'(wb1_wd), 64'hAB);
      chk("byp_cnt", 64'(fifo_cnt), 64'd0);

      // Collision deferral and sticky flag.
      busy_lt(6, 32'h66);
      chk("pre_conf", 64'(wb_conflict), 64'd0);
      step(1, 6, 32'h61, 0, 0, 0, 0, 0, 0);
      chk("col_wb2_we", 64'(wb2_we), 64'd0);
      chk("col_conf", 64'(wb_conflict), 64'd1);
      chk("col_cnt", 64'(fifo_cnt), 64'd1);
      idle();
      chk("col_drain_wa", 64'(wb1_wa), 64'd6);
      chk("col_drain_wd", 64'(wb1_wd), 64'h66);
      chk("col_sticky", 64'(wb_conflict), 64'd1);

      // Head and head+1 share an address.
      busy_lt(8, 32'h1);
      busy_lt(8, 32'h2);
      idle();
      chk("intra_a_wd", 64'(wb1_wd), 64'h1);
      chk("intra_a_p2", 64'(wb2_we), 64'd0);
      idle();
      chk("intra_b_wd", 64'(wb1_wd), 64'h2);

      // Reset with three entries held.
      for (int k = 0; k < 3; k++) busy_lt(AW'(20 + k), 32'hC0 + k);
      chk("mid_cnt", 64'(fifo_cnt), 64'd3);
      do_reset();

      // Random traffic over a small address range to provoke collisions.
      for (int n = 0; n < 400; n++) begin
         if (n == 200) do_reset();
         step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
              1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom(),
              1'($urandom_range(0, 2) != 0), AW'($urandom_range(0, 7)), $urandom());
      end
      repeat (4) idle();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
